// File: rtl/lane_motion_scheduler_if.sv
// Control and position bundle between the game logic and lane_motion_scheduler.
// Car_X is indexed [row][slot]; every field is sampled or driven on Clk.
interface lane_motion_scheduler_if;
    logic                   frame_tick;
    logic                   Run;
    logic                   Freeze;
    logic [3:0][3:0]        Row_Period;
    logic [3:0][3:0]        Row_Step;
    logic [3:0]             Row_Dir;
    logic [3:0][3:0][10:0]  Car_X;
    logic                   Busy;
    logic                   Update_Done;
    logic                   Overrun;

    modport master (
        output frame_tick, Run, Freeze, Row_Period, Row_Step, Row_Dir,
        input  Car_X, Busy, Update_Done, Overrun
    );

    modport slave (
        input  frame_tick, Run, Freeze, Row_Period, Row_Step, Row_Dir,
        output Car_X, Busy, Update_Done, Overrun
    );
endinterface

// File: rtl/lane_motion_scheduler.sv
// Per-frame X stepper for 16 car slots (4 rows x 4 slots).
// One shared add/wrap unit is walked over the slots by a small FSM.
module lane_motion_scheduler #(
    parameter int WRAP_X       = 720,
    parameter int SLOT_SPACING = 180,
    parameter int ROW_STAGGER  = 40
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    lane_motion_scheduler_if.slave  io
);

    typedef enum logic [1:0] {IDLE, DIV, MOVE, DONE} state_t;

    localparam logic [11:0] WRAP = 12'(WRAP_X);

    state_t                 state;
    logic [3:0][3:0]        cnt;
    logic [3:0]             mv;
    logic [3:0]             idx;
    logic                   pending;
    logic [3:0][3:0][10:0]  car_x;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    logic                   accept;
    logic [1:0]             row;
    logic [10:0]            cur;
    logic [11:0]            wide;
    logic [11:0]            step;
    logic [11:0]            sum;
    logic [10:0]            nxt;

    assign accept = io.frame_tick & io.Run & ~io.Freeze;
    assign row    = idx[3:2];

    always_comb begin
        cur  = car_x[row][idx[1:0]];
        wide = {1'b0, cur};
        step = {8'h00, io.Row_Step[row]};
        sum  = wide + step;
        if (io.Row_Dir[row])
            nxt = 11'((sum >= WRAP) ? sum - WRAP : sum);
        else
            nxt = 11'((wide < step) ? wide + WRAP - step : wide - step);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mv      <= '0;
            idx     <= '0;
            pending <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int r = 0; r < 4; r++)
                for (int s = 0; s < 4; s++)
                    car_x[r][s] <= 11'(s * SLOT_SPACING + r * ROW_STAGGER);
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= DIV;
                        busy  <= 1'b1;
                    end
                end
                DIV: begin
                    for (int r = 0; r < 4; r++) begin
                        if (cnt[r] >= io.Row_Period[r]) begin
                            cnt[r] <= '0;
                            mv[r]  <= 1'b1;
                        end else begin
                            cnt[r] <= cnt[r] + 4'd1;
                            mv[r]  <= 1'b0;
                        end
                    end
                    idx   <= '0;
                    state <= MOVE;
                end
                MOVE: begin
                    if (mv[row])
                        car_x[row][idx[1:0]] <= nxt;
                    idx <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // a tick landing in DONE with nothing queued starts the next pass directly
                    if (pending || accept) begin
                        state <= DIV;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == DONE) begin
                pending <= pending & accept;
            end else if (state != IDLE && accept) begin
                if (pending)
                    overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end
        end
    end

    assign io.Car_X       = car_x;
    assign io.Busy        = busy;
    assign io.Update_Done = done;
    assign io.Overrun     = overrun;

endmodule

// File: tb/tb_lane_motion_scheduler.sv
// Directed bench for lane_motion_scheduler; expected values worked out by hand.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lane_motion_scheduler;

    typedef logic [3:0][3:0][10:0] carx_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    total = 0;
    int    bad = 0;
    int    n;
    int    dones;
    carx_t rst_x;
    carx_t exp_x;
    int    e_row1[6] = '{40, 40, 41, 41, 41, 42};

    always #5 clk = ~clk;

    lane_motion_scheduler_if io();

    lane_motion_scheduler dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .io      (io)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_x(input string tag, input carx_t expv);
        total++;
        assert (io.Car_X === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, io.Car_X, expv);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        io.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // returns on the falling edge of the first cycle after the sampling edge
    task automatic pulse;
        io.frame_tick = 1'b1;
        @(negedge clk);
        io.frame_tick = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!io.Update_Done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic one_update;
        int c;
        pulse();
        wait_done(c);
        chk("update_latency", c, 18);
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        io.frame_tick = 1'b0;
        io.Run        = 1'b0;
        io.Freeze     = 1'b0;
        io.Row_Period = '0;
        io.Row_Step   = '0;
        io.Row_Dir    = '0;
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++)
                rst_x[r][s] = 11'(s * 180 + r * 40);

        do_reset();
        chk_x("reset_x", rst_x);
        chk("reset_busy", 32'(io.Busy), 0);
        chk("reset_done", 32'(io.Update_Done), 0);
        chk("reset_overrun", 32'(io.Overrun), 0);

        // basic right step of one pixel, latency and Busy window
        io.Run      = 1'b1;
        io.Row_Step = {4{4'd1}};
        io.Row_Dir  = 4'hF;
        pulse();
        chk("t1_busy_e1", 32'(io.Busy), 1);
        wait_done(n);
        chk("t1_done_latency", n, 18);
        chk("t1_busy_at_done", 32'(io.Busy), 1);
        @(negedge clk);
        chk("t1_idle_busy", 32'(io.Busy), 0);
        chk("t1_done_one_cycle", 32'(io.Update_Done), 0);
        chk("t1_x23", 32'(io.Car_X[2][3]), 621);
        chk("t1_x00", 32'(io.Car_X[0][0]), 1);
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++)
                exp_x[r][s] = rst_x[r][s] + 11'd1;
        chk_x("t1_all", exp_x);

        // left wrap, then right wrap
        do_reset();
        io.Row_Step    = '0;
        io.Row_Dir     = 4'b0000;
        io.Row_Step[0] = 4'd5;
        io.Row_Step[1] = 4'd10;
        one_update();
        chk("t2_left_wrap", 32'(io.Car_X[0][0]), 715);
        io.Row_Step[0] = 4'd0;
        repeat (4) one_update();
        chk("t2_row1_710", 32'(io.Car_X[1][0]), 710);
        io.Row_Dir[1]  = 1'b1;
        io.Row_Step[1] = 4'd15;
        one_update();
        chk("t2_right_wrap", 32'(io.Car_X[1][0]), 5);
        chk("t2_r1s1", 32'(io.Car_X[1][1]), 185);
        chk("t2_r1s3", 32'(io.Car_X[1][3]), 545);
        chk("t2_r0s3", 32'(io.Car_X[0][3]), 535);
        chk("t2_r2s3_still", 32'(io.Car_X[2][3]), 620);

        // row 1 divided by three
        do_reset();
        io.Row_Step      = {4{4'd1}};
        io.Row_Dir       = 4'hF;
        io.Row_Period    = '0;
        io.Row_Period[1] = 4'd2;
        for (int i = 0; i < 6; i++) begin
            one_update();
            chk("t3_row1", 32'(io.Car_X[1][0]), e_row1[i]);
            chk("t3_row0", 32'(io.Car_X[0][0]), i + 1);
        end
        io.Row_Period = '0;

        // two extra ticks during MOVE: one queues, one overruns
        do_reset();
        pulse();
        repeat (2) @(negedge clk);
        pulse();
        chk("t4_no_overrun_yet", 32'(io.Overrun), 0);
        pulse();
        chk("t4_overrun", 32'(io.Overrun), 1);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            if (io.Update_Done) dones++;
            @(negedge clk);
        end
        chk("t4_updates", dones, 2);
        chk("t4_idle", 32'(io.Busy), 0);
        chk("t4_x00", 32'(io.Car_X[0][0]), 2);
        chk("t4_overrun_sticky", 32'(io.Overrun), 1);

        // tick landing in DONE while one is queued
        do_reset();
        pulse();
        repeat (2) @(negedge clk);
        pulse();
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (io.Update_Done) begin
                dones++;
                io.frame_tick = (dones == 1);
            end else begin
                io.frame_tick = 1'b0;
            end
            @(negedge clk);
        end
        io.frame_tick = 1'b0;
        chk("t4b_updates", dones, 3);
        chk("t4b_no_overrun", 32'(io.Overrun), 0);
        chk("t4b_x00", 32'(io.Car_X[0][0]), 3);

        // gating by Freeze and Run
        do_reset();
        io.Freeze = 1'b1;
        pulse();
        @(negedge clk);
        chk("t5_freeze_busy", 32'(io.Busy), 0);
        io.Freeze = 1'b0;
        io.Run    = 1'b0;
        pulse();
        @(negedge clk);
        chk("t5_norun_busy", 32'(io.Busy), 0);
        repeat (20) @(negedge clk);
        chk_x("t5_unchanged", rst_x);
        io.Run = 1'b1;
        pulse();
        repeat (3) @(negedge clk);
        io.Freeze = 1'b1;
        wait_done(n);
        @(negedge clk);
        chk("t5_midfreeze_x00", 32'(io.Car_X[0][0]), 1);
        chk("t5_midfreeze_x33", 32'(io.Car_X[3][3]), 661);
        io.Freeze = 1'b0;

        // reset in the middle of MOVE
        do_reset();
        pulse();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_x("t6_abort_x", rst_x);
        chk("t6_abort_busy", 32'(io.Busy), 0);
        chk("t6_abort_done", 32'(io.Update_Done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        one_update();
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++)
                exp_x[r][s] = rst_x[r][s] + 11'd1;
        chk_x("t6_full_update", exp_x);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
